// File: rtl/i2c_target_mem_if.sv
// Bus bundle for the I2C target memory: line levels in, open-drain SDA enable and write-notify out.
interface i2c_target_mem_if #(
  parameter int PTR_W = 4
);
  logic             scl_i;
  logic             sda_i;
  logic             sda_oe;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_ptr;
  logic [7:0]       wr_data;
  logic             busy;

  modport master (
    output scl_i, sda_i,
    input  sda_oe, wr_strobe, wr_ptr, wr_data, busy
  );

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, wr_strobe, wr_ptr, wr_data, busy
  );
endinterface

// File: rtl/i2c_target_mem.sv
// I2C target with a 2**PTR_W byte register file; pointer-addressed writes, sequential reads.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on both lines (+2 clk latency).
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h10,
  parameter int         PTR_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  i2c_target_mem_if.slave bus
);

  localparam int DEPTH = 2 ** PTR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t           state, state_nxt;
  logic             scl_p0, scl_p1, sda_p0, sda_p1;
  logic             scl, sda, scl_d, sda_d;
  logic             scl_rise, scl_fall, start_c, stop_c;
  logic [2:0]       cnt;
  logic             ack9;
  logic [7:0]       sh, rx_byte, rd_byte;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       mem [DEPTH];

  logic oe_nxt, ld_rd, wr_en, ptr_ld, ptr_inc, busy_set, rx_shift, tx_shift, bit_cnt_en, is_ack;

  // Stage p0/p1: two-flop synchronisers; idle bus level is high so reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_i;
      scl_p1 <= scl_p0;
      sda_p0 <= bus.sda_i;
      sda_p1 <= sda_p0;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] scl_h, sda_h;
  logic       scl_f, sda_f;

  // Stage p2: majority vote over the last three synchronised samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_p1};
      sda_h <= {sda_h[0], sda_p1};
      scl_f <= maj3(scl_p1, scl_h[0], scl_h[1]);
      sda_f <= maj3(sda_p1, sda_h[0], sda_h[1]);
    end
  end

  assign scl = scl_f;
  assign sda = sda_f;
`else
  assign scl = scl_p1;
  assign sda = sda_p1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl;
      sda_d <= sda;
    end
  end

  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_c  = scl & scl_d & sda_d & ~sda;
  assign stop_c   = scl & scl_d & ~sda_d & sda;
  assign rx_byte  = {sh[6:0], sda};
  assign rd_byte  = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_c) begin
      state_nxt = IDLE;
    end else if (start_c) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:      if (scl_rise && cnt == 3'd7)
                     state_nxt = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (scl_fall && ack9) state_nxt = sh[0] ? RDATA : PTR;
        PTR:       if (scl_rise && cnt == 3'd7) state_nxt = PTR_ACK;
        PTR_ACK:   if (scl_fall && ack9) state_nxt = WDATA;
        WDATA:     if (scl_rise && cnt == 3'd7) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall && ack9) state_nxt = WDATA;
        RDATA:     if (scl_rise && cnt == 3'd7) state_nxt = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda)       state_nxt = IGNORE;
          else if (scl_fall && ack9) state_nxt = RDATA;
        end
        default:   state_nxt = state;
      endcase
    end
  end

  // ack9 marks that the 9th SCL rise of an acknowledge slot has been seen.
  always_comb begin
    oe_nxt     = bus.sda_oe;
    ld_rd      = 1'b0;
    wr_en      = 1'b0;
    ptr_ld     = 1'b0;
    ptr_inc    = 1'b0;
    busy_set   = 1'b0;
    rx_shift   = 1'b0;
    tx_shift   = 1'b0;
    bit_cnt_en = 1'b0;
    is_ack     = 1'b0;
    if (stop_c || start_c) begin
      oe_nxt = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          rx_shift   = scl_rise;
          bit_cnt_en = scl_rise;
          if (scl_rise && cnt == 3'd7) begin
            busy_set = (state == ADDR) && (rx_byte[7:1] == DEV_ADDR);
            ptr_ld   = (state == PTR);
            wr_en    = (state == WDATA);
            ptr_inc  = (state == WDATA);
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          is_ack = 1'b1;
          if (scl_fall) oe_nxt = ~ack9;
          if (state == ADDR_ACK && scl_fall && ack9 && sh[0]) begin
            ld_rd  = 1'b1;
            oe_nxt = ~rd_byte[7];
          end
        end
        RDATA: begin
          bit_cnt_en = scl_rise;
          tx_shift   = scl_fall;
          if (scl_fall) oe_nxt = ~sh[6];
        end
        RDATA_ACK: begin
          is_ack = 1'b1;
          if (scl_fall && !ack9) oe_nxt = 1'b0;
          if (scl_rise && !sda) ptr_inc = 1'b1;
          if (scl_fall && ack9) begin
            ld_rd  = 1'b1;
            oe_nxt = ~rd_byte[7];
          end
        end
        default: oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      ack9          <= 1'b0;
      ptr           <= '0;
      bus.sda_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_ptr    <= '0;
      bus.wr_data   <= '0;
    end else begin
      bus.sda_oe    <= oe_nxt;
      bus.wr_strobe <= wr_en;
      if (wr_en) begin
        bus.wr_ptr  <= ptr;
        bus.wr_data <= rx_byte;
      end
      if (start_c || stop_c) cnt <= '0;
      else if (bit_cnt_en)   cnt <= cnt + 3'd1;
      ack9 <= is_ack & (ack9 | scl_rise);
      if (ptr_ld)       ptr <= rx_byte[PTR_W-1:0];
      else if (ptr_inc) ptr <= ptr + 1'b1;
      if (stop_c)        bus.busy <= 1'b0;
      else if (busy_set) bus.busy <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_rd)         sh <= rd_byte;
    else if (rx_shift) sh <= rx_byte;
    else if (tx_shift) sh <= {sh[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-banged I2C initiator plus a byte-array model of the register file.
module tb_i2c_target_mem;

  localparam int         PTR_W = 4;
  localparam int         DEPTH = 16;
  localparam int         Q     = 8;
  localparam logic [7:0] AW    = 8'h20;
  localparam logic [7:0] AR    = 8'h21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  int   total = 0;
  int   bad = 0;

  logic [7:0]       mem_m [DEPTH];
  logic [11:0]      wq [$];

  i2c_target_mem_if #(.PTR_W(PTR_W)) bus ();

  i2c_target_mem #(.DEV_ADDR(7'h10), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign sda_line  = sda_m & ~bus.sda_oe;
  assign bus.sda_i = sda_line;
  assign bus.scl_i = scl_m;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_strobe === 1'b1) wq.push_back({bus.wr_ptr, bus.wr_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, output logic r);
    repeat (2) @(negedge clk);
    sda_m = b;
    repeat (Q - 2) @(negedge clk);
    scl_m = 1'b1;
    repeat (Q / 2) @(negedge clk);
    r = sda_line;
    repeat (Q / 2) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start;
    repeat (2) @(negedge clk);
    sda_m = 1'b1;
    repeat (Q) @(negedge clk);
    scl_m = 1'b1;
    repeat (Q) @(negedge clk);
    sda_m = 1'b0;
    repeat (Q) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    repeat (2) @(negedge clk);
    sda_m = 1'b0;
    repeat (Q) @(negedge clk);
    scl_m = 1'b1;
    repeat (Q) @(negedge clk);
    sda_m = 1'b1;
    repeat (Q) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(nack, r);
  endtask

  task automatic model_clear;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b want=0", bus.sda_oe); end
    total++; if (bus.wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe got=%b want=0", bus.wr_strobe); end
    total++; if (bus.wr_ptr !== 4'h0) begin bad++; $display("FAIL reset_wr_ptr got=%h want=0", bus.wr_ptr); end
    total++; if (bus.wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", bus.wr_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    rst = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    wq.delete();
    i2c_start();
    write_byte(AW, a0);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL write_busy_on got=%b want=1", bus.busy); end
    write_byte(8'h03, a1);
    write_byte(8'h27, a2);
    i2c_stop();
    mem_m[3] = 8'h27;
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL write_acks got=%b want=111", {a0, a1, a2}); end
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL write_strobe_count got=%0d want=1", wq.size()); end
    if (wq.size() > 0) begin
      total++; if (wq[0] !== {4'h3, 8'h27}) begin bad++; $display("FAIL write_strobe_val got=%h want=327", wq[0]); end
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL write_busy_off got=%b want=0", bus.busy); end
  endtask

  task automatic test_random_read;
    logic a;
    logic [7:0] d;
    i2c_start();
    write_byte(AW, a);
    write_byte(8'h03, a);
    i2c_start();
    write_byte(AR, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rread_addr_ack got=%b want=1", a); end
    read_byte(1'b1, d);
    i2c_stop();
    total++; if (d !== mem_m[3]) begin bad++; $display("FAIL rread_data got=%h want=%h", d, mem_m[3]); end
    total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL rread_release got=%b want=0", bus.sda_oe); end
  endtask

  task automatic test_addr_miss;
    logic a0, a1;
    wq.delete();
    i2c_start();
    write_byte(8'h22, a0);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL miss_busy got=%b want=0", bus.busy); end
    write_byte(8'h05, a1);
    write_byte(8'h55, a1);
    i2c_stop();
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL miss_ack got=%b want=0", a0); end
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL miss_strobes got=%0d want=0", wq.size()); end
  endtask

  task automatic test_wrap;
    logic a;
    logic [7:0] d0, d1;
    wq.delete();
    i2c_start();
    write_byte(AW, a);
    write_byte(8'h0F, a);
    write_byte(8'hA1, a);
    write_byte(8'hB2, a);
    i2c_stop();
    mem_m[15] = 8'hA1;
    mem_m[0]  = 8'hB2;
    total++; if (wq.size() !== 2) begin bad++; $display("FAIL wrap_strobe_count got=%0d want=2", wq.size()); end
    if (wq.size() == 2) begin
      total++; if (wq[0] !== {4'hF, 8'hA1}) begin bad++; $display("FAIL wrap_strobe0 got=%h want=fa1", wq[0]); end
      total++; if (wq[1] !== {4'h0, 8'hB2}) begin bad++; $display("FAIL wrap_strobe1 got=%h want=0b2", wq[1]); end
    end
    i2c_start();
    write_byte(AW, a);
    write_byte(8'h0F, a);
    i2c_start();
    write_byte(AR, a);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    total++; if (d0 !== 8'hA1) begin bad++; $display("FAIL wrap_read0 got=%h want=a1", d0); end
    total++; if (d1 !== 8'hB2) begin bad++; $display("FAIL wrap_read1 got=%h want=b2", d1); end
  endtask

  task automatic test_rst_mid_read;
    logic a, r;
    logic [7:0] d;
    i2c_start();
    write_byte(AW, a);
    write_byte(8'h03, a);
    write_byte(8'h27, a);
    i2c_start();
    write_byte(AW, a);
    write_byte(8'h03, a);
    i2c_start();
    write_byte(AR, a);
    for (int i = 0; i < 3; i++) send_bit(1'b1, r);
    repeat (5) @(negedge clk);
    total++; if (bus.sda_oe !== 1'b1) begin bad++; $display("FAIL rstmid_driving got=%b want=1", bus.sda_oe); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_release got=%b want=0", bus.sda_oe); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    rst = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    i2c_start();
    write_byte(AR, a);
    read_byte(1'b1, d);
    i2c_stop();
    total++; if (d !== mem_m[0]) begin bad++; $display("FAIL rstmid_readback got=%h want=%h", d, mem_m[0]); end
  endtask

  task automatic test_glitch;
    logic a, r;
    wq.delete();
    i2c_start();
    write_byte(AW, a);
    write_byte(8'h08, a);
    repeat (2) @(negedge clk);
    sda_m = 1'b1;
    repeat (Q - 2) @(negedge clk);
    scl_m = 1'b1;
    repeat (4) @(negedge clk);
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    repeat (Q - 5) @(negedge clk);
    scl_m = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1, r);
    send_bit(1'b1, r);
    i2c_stop();
`ifdef I2C_GLITCH_FILTER_EN
    mem_m[8] = 8'hFF;
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL glitch_filtered got=%0d strobes want=1", wq.size()); end
`else
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL glitch_abort got=%0d strobes want=0", wq.size()); end
`endif
  endtask

  task automatic test_random;
    logic a;
    logic [7:0] pb, d, got;
    logic [3:0] p;
    logic [11:0] exp_q [$];
    int n;
    for (int it = 0; it < 10; it++) begin
      wq.delete();
      exp_q.delete();
      pb = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 4);
      p  = pb[3:0];
      i2c_start();
      write_byte(AW, a);
      write_byte(pb, a);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        write_byte(d, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL rnd_wr_ack it=%0d got=%b want=1", it, a); end
        exp_q.push_back({p, d});
        mem_m[p] = d;
        p = p + 4'd1;
      end
      i2c_stop();
      total++; if (wq.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_strobe_count it=%0d got=%0d want=%0d", it, wq.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < wq.size(); k++) begin
        total++; if (wq[k] !== exp_q[k]) begin bad++; $display("FAIL rnd_strobe it=%0d k=%0d got=%h want=%h", it, k, wq[k], exp_q[k]); end
      end
      pb = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 4);
      p  = pb[3:0];
      i2c_start();
      write_byte(AW, a);
      write_byte(pb, a);
      i2c_start();
      write_byte(AR, a);
      for (int k = 0; k < n; k++) begin
        read_byte(k == n - 1, got);
        total++; if (got !== mem_m[p]) begin bad++; $display("FAIL rnd_read it=%0d ptr=%0d got=%h want=%h", it, p, got, mem_m[p]); end
        p = p + 4'd1;
      end
      i2c_stop();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_addr_miss();
    test_wrap();
    test_random();
    test_rst_mid_read();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
